// File: rtl/oka8_pkg.sv
// Shared types and helpers for the oka8 dot-product accumulator.
package oka8_pkg;

  // Vector-tracking state: idle means the next advancing beat starts a new vector.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  // Operand width of the truncated multiplier.
  localparam int OPW = 8;

  // Saturating increment for a counter of width w (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/oka8_mul_lo.sv
// Combinational 8x8 multiplier keeping only the low byte: y = (a*b) mod 256.
// The gate-level multiplier netlist drops in for this module in synthesis.
module oka8_mul_lo
  import oka8_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic [OPW-1:0] y
);

  // Self-determined 8-bit product truncates to the low half.
  assign y = a * b;

endmodule

// File: rtl/oka8_dot_accum.sv
// Dot-product accumulator around the truncated multiplier.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; the sender holds its data stable while valid && !ready, and a
// receiver may drop ready at any time. in_ready is combinational from
// out_ready and clr; every other output comes straight from a flop.
module oka8_dot_accum
  import oka8_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_a,
  input  logic [OPW-1:0]   in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [OPW-1:0]     s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic               s1_last_q, s1_last_d, s1_valid_q, s1_valid_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;

  logic [OPW-1:0]     mul_y;
  logic               s1_adv, accept, carry;
  logic [ACC_W-1:0]   acc_base;
  logic [CNT_W-1:0]   cnt_base, cnt_inc;
  logic [ACC_W:0]     prod, sum;

  oka8_mul_lo u_mul (
    .a (s1_a_q),
    .b (s1_b_q),
    .y (mul_y)
  );

  // Stage advance, input handshake and the accumulate datapath.
  always_comb begin
    // A last beat waits only while the output register is full and not being drained.
    s1_adv   = s1_valid_q && !clr && !(s1_last_q && out_valid_q && !out_ready);
    in_ready = !clr && (!s1_valid_q || s1_adv);
    accept   = in_valid && in_ready;
    acc_base = (state_q == ST_IDLE) ? '0 : acc_q;
    cnt_base = (state_q == ST_IDLE) ? '0 : cnt_q;
    cnt_inc  = CNT_W'(sat_inc(32'(cnt_base), CNT_W));
    prod     = (ACC_W+1)'(mul_y);
    sum      = {1'b0, acc_base} + prod;
    carry    = sum[ACC_W];
  end

  // FSM next state: a last beat or clr closes the vector, any other beat opens it.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
    end else if (s1_adv) begin
      state_d = s1_last_q ? ST_IDLE : ST_ACCUM;
    end
  end

  // FSM outputs: next values for S1, the running sums and the output register.
  always_comb begin
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_last_d   = s1_last_q;
    s1_valid_d  = s1_valid_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    if (clr) begin
      s1_valid_d = 1'b0;
    end else if (accept) begin
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_last_d  = in_last;
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (s1_adv && !s1_last_q) begin
      acc_d = sum[ACC_W-1:0];
      cnt_d = cnt_inc;
      ovf_d = ovf_q | carry;
    end else if (s1_adv && s1_last_q) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end

    // A loading result wins over a drain in the same cycle.
    if (s1_adv && s1_last_q) begin
      out_valid_d = 1'b1;
      out_data_d  = sum[ACC_W-1:0];
      out_count_d = cnt_inc;
      out_ovf_d   = ovf_q | carry;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers: S1 operands, running sums and the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_last_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_last_q   <= s1_last_d;
      s1_valid_q  <= s1_valid_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_oka8_dot_accum.sv
// Directed bench for oka8_dot_accum: hand-computed results go into an
// expected queue that a monitor drains on every output handshake.
module tb_oka8_dot_accum;

  localparam int ACC_W = 16;
  localparam int CNT_W = 8;
  localparam int EXP_W = 1 + CNT_W + ACC_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_a = '0;
  logic [7:0]       in_b = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  oka8_dot_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] sb_e;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic ovf, input int cnt, input int data);
    exp_q.push_back({ovf, CNT_W'(cnt), ACC_W'(data)});
  endtask

  // ---------------- driver tasks ----------------
  // Present one beat at a negedge, wait (bounded) for in_ready, return at the
  // negedge after the accepting edge.
  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic last,
                           output int stalls);
    stalls   = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    #1;
    while (!in_ready && stalls < 50) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (!in_ready) check("send_accept", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    int s;
    send_beat(a, b, last, s);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_extra", out_valid, 0);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_data",  out_data,  sb_e[ACC_W-1:0]);
          check("sb_count", out_count, sb_e[ACC_W +: CNT_W]);
          check("sb_ovf",   out_ovf,   sb_e[EXP_W-1]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int stall_total;
    int s;
    int w;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_out_count", out_count, 0);
    check("rst_out_ovf",   out_ovf,   0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Single beat 3*5, latency check
    out_ready = 1'b1;
    push_exp(0, 1, 15);
    send(8'd3, 8'd5, 1'b1);
    idle();
    #1;
    check("lat_t1_valid", out_valid, 0);
    @(negedge clk);
    #1;
    check("lat_t2_valid", out_valid, 1);
    check("lat_t2_data",  out_data,  15);
    repeat (3) @(negedge clk);

    // Back-to-back vector with wrapping products: 64 + 1 + 0
    push_exp(0, 3, 65);
    stall_total = 0;
    send_beat(8'd200, 8'd200, 1'b0, s); stall_total += s;
    send_beat(8'd255, 8'd255, 1'b0, s); stall_total += s;
    send_beat(8'd16,  8'd16,  1'b1, s); stall_total += s;
    idle();
    check("vec_no_stall", stall_total, 0);
    repeat (3) @(negedge clk);

    // 258 beats of 255: sum 65790 mod 65536 = 254, count saturates
    push_exp(1, 255, 254);
    for (int i = 0; i < 258; i++) send(8'd15, 8'd17, (i == 257));
    idle();
    repeat (3) @(negedge clk);

    // Backpressure
    out_ready = 1'b0;
    push_exp(0, 1, 6);
    send(8'd2, 8'd3, 1'b1);
    idle();
    repeat (2) @(negedge clk);
    #1;
    check("bp_holdA_valid", out_valid, 1);
    check("bp_holdA_data",  out_data,  6);
    @(negedge clk);
    push_exp(0, 2, 41);
    send(8'd4, 8'd4, 1'b0);
    in_valid = 1'b1; in_a = 8'd5; in_b = 8'd5; in_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("bp_stall_ready", in_ready, 0);
    idle();
    repeat (2) @(negedge clk);
    #1;
    check("bp_stall_ready2", in_ready,  0);
    check("bp_stable_data",  out_data,  6);
    check("bp_stable_count", out_count, 1);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_B_valid", out_valid, 1);
    check("bp_B_data",  out_data,  41);
    check("bp_B_count", out_count, 2);
    repeat (3) @(negedge clk);

    // Last every cycle: no bubbles
    for (int k = 1; k <= 7; k++) push_exp(0, 1, k * k);
    fork
      begin
        for (int k = 1; k <= 7; k++) send(8'(k), 8'(k), 1'b1);
        idle();
      end
      begin
        w = 0;
        while (!out_valid && w < 20) begin
          @(negedge clk);
          #1;
          w++;
        end
        check("stream_start", out_valid, 1);
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          #1;
          check("stream_valid", out_valid, 1);
        end
        @(negedge clk);
        #1;
        check("stream_end", out_valid, 0);
      end
    join
    repeat (3) @(negedge clk);

    // Mid-vector reset
    send(8'd9, 8'd9, 1'b0);
    send(8'd9, 8'd9, 1'b0);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_ready", in_ready,  1);
    rst_n = 1'b1;
    @(negedge clk);
    push_exp(0, 1, 1);
    send(8'd1, 8'd1, 1'b1);
    idle();
    repeat (4) @(negedge clk);

    // Mid-vector clr with a pending output held
    out_ready = 1'b0;
    push_exp(0, 1, 4);
    send(8'd2, 8'd2, 1'b1);
    send(8'd9, 8'd9, 1'b0);
    send(8'd9, 8'd9, 1'b0);
    clr = 1'b1;
    in_valid = 1'b1; in_a = 8'd7; in_b = 8'd7; in_last = 1'b1;
    #1;
    check("clr_ready", in_ready, 0);
    @(negedge clk);
    clr = 1'b0;
    idle();
    #1;
    check("clr_keep_valid", out_valid, 1);
    check("clr_keep_data",  out_data,  4);
    @(negedge clk);
    push_exp(0, 1, 1);
    send(8'd1, 8'd1, 1'b1);
    idle();
    repeat (2) @(negedge clk);
    out_ready = 1'b1;

    // Drain and report
    w = 0;
    while (exp_q.size() > 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/oka8_dot_accum.md
Name: oka8_dot_accum

Overview:
- Sequential stage that wraps the 8-bit low-half multiplier, where y = (a*b) mod 256.
- Accepts a stream of operand pairs over valid/ready, registers each pair into the multiplier, and accumulates the 8-bit products into a dot-product sum.
- Emits one result per vector, delimited by in_last, through a held valid/ready output register.
- Sits upstream of any consumer of multiplier results; used as the system-level harness for the truncated multiplier.

Parameters:
- ACC_W, 16: accumulator and out_data width. Must be ≥ 8.
- CNT_W, 8: beat-counter and out_count width. The count saturates at 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous discard of the partial vector.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- in_a  input  8  multiplicand.
- in_b  input  8  multiplier.
- in_last  input  1  final beat of the vector.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  ACC_W  sum of (a*b mod 256), mod 2^ACC_W.
- out_count  output  CNT_W  beats in the vector, saturating.
- out_ovf  output  1  accumulator carried out at least once during the vector.

Behaviour:
- Reset: async on rst_n=0. Clears s1_valid, acc, cnt, ovf, out_valid, out_data, out_count, out_ovf and state to 0/ST_IDLE. A partial vector is discarded; the first beat after release starts a new vector.
- Stage S1 holds s1_a, s1_b, s1_last, s1_valid, loaded on accept. The multiplier is combinational from s1_a/s1_b.
- s1_adv = s1_valid && !clr && !(s1_last && out_valid && !out_ready).
- in_ready = !clr && (!s1_valid || s1_adv). This is combinational from out_ready; the path is permitted.
- prod = zero-extend(mul(s1_a, s1_b)) to ACC_W+1 bits.
- sum = (state==ST_IDLE ? 0 : acc) + prod. carry = sum[ACC_W].
- On s1_adv with s1_last=0:
  - acc <= sum[ACC_W-1:0].
  - cnt <= sat(cnt+1).
  - ovf <= ovf | carry.
  - state <= ST_ACCUM.
- On s1_adv with s1_last=1:
  - out_data <= sum[ACC_W-1:0].
  - out_count <= sat(cnt+1), where cnt is taken as 0 in ST_IDLE.
  - out_ovf <= ovf | carry.
  - out_valid <= 1.
  - acc, cnt, ovf <= 0; state <= ST_IDLE.
- Output register:
  - out_valid clears on out_ready only if no new result loads that cycle.
  - Simultaneous out handshake and new last: the new result loads and out_valid stays 1.
  - out_* are stable while out_valid && !out_ready.
- Latency: a last beat accepted at cycle T gives out_valid high from T+2 when unstalled. Throughput is 1 beat/cycle.
- Stall: only a last beat in S1 stalls, and only while the output is occupied and not being taken. Non-last beats keep accumulating behind a held output.
- clr:
  - acc, cnt, ovf <= 0; s1_valid <= 0; state <= ST_IDLE; in_ready=0.
  - The output register is unaffected.
  - A beat presented during clr is not accepted.
- Single-beat vector (in_last on the first beat): out_count=1, out_data=prod.
- Count saturation: cnt stops at 2^CNT_W-1. Accumulation continues mod 2^ACC_W, with ovf sticky.
- All outputs are registered except in_ready.

Decomposition:
- Package oka8_pkg:
  - state typedef with ST_IDLE=1'b0 and ST_ACCUM=1'b1.
  - OPW=8 operand width constant.
  - sat_inc function used by the counter.
- One sub-module, oka8_mul_lo: combinational, ports a[7:0], b[7:0], y[7:0], with y = (a*b) mod 256. The gate-level multiplier netlist is drop-in for it in synthesis.

Test Plan:
- Single beat, a=3, b=5, last=1, out_ready=1 → out_valid at T+2 with out_data=15, out_count=1, out_ovf=0.
- Vector (200,200),(255,255),(16,16,last) back-to-back → products 64, 1, 0; out_data=65, out_count=3; in_ready stays 1 throughout.
- 258 beats of (15,17,product 255), last on beat 258 → out_data=254, out_ovf=1, out_count=255 (saturated).
- Backpressure, out_ready=0:
  - Vector A = (2,3,last) gives out_data=6 and holds.
  - Vector B = (4,4),(5,5,last): the last beat stalls in S1 and in_ready=0.
  - Raise out_ready → A taken; next cycle out_data=41, out_count=2.
- Continuous out_ready=1 with a last every cycle, (1,1)…(7,7) → out_valid continuously high, out_data=1,4,9,…,49 in order, no bubbles.
- Mid-vector disruption:
  - Reset: 2 beats of (9,9), assert rst_n=0 for one cycle, then (1,1,last) → out_data=1, out_count=1.
  - clr: same sequence using clr instead of reset gives the same result, and any pending output is preserved.
